// File: rtl/sid_arb_pkg.sv
// Shared constants and encodings for the SID write arbiter.
// Optional build macro used by the top level: SID_ARB_SHADOW_EN.
package sid_arb_pkg;

   localparam int ADDR_W_DEF = 5;

   // A host address byte has bit 7 set and bits 6:5 clear.
   localparam logic [7:0] ADDR_MARK = 8'h80;
   localparam logic [7:0] RSV_MASK  = 8'h60;

   typedef enum logic {
      PS_ADDR,
      PS_DATA
   } ps_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_BUS,
      SRC_PEND,
      SRC_HOST
   } src_t;

endpackage

// File: rtl/sid_arb_fifo.sv
// Synchronous FIFO for parsed host register writes.
// DEPTH must be a power of two so the pointers wrap naturally.
module sid_arb_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   level_reg;

   // Storage carries no reset; only the pointers define valid contents.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

   assign pop_data = mem[rd_ptr_reg];
   assign full     = (level_reg == (PTR_W+1)'(DEPTH));
   assign empty    = (level_reg == '0);
   assign level    = level_reg;

endmodule

// File: rtl/sid_write_arbiter.sv
// Merges C64 bus writes and host (addr,data) byte pairs onto the SID write port,
// one write per clk_en slot, bus first. Macro SID_ARB_SHADOW_EN adds a readable shadow copy.
module sid_write_arbiter
   import sid_arb_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = sid_arb_pkg::ADDR_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clk_en,
   input  logic                          bus_we,
   input  logic [ADDR_W-1:0]             bus_addr,
   input  logic [7:0]                    bus_wdata,
   input  logic [7:0]                    host_data,
   input  logic                          host_valid,
   output logic                          host_ready,
   output logic                          sid_clk_en,
   output logic                          sid_we,
   output logic [ADDR_W-1:0]             sid_addr,
   output logic [7:0]                    sid_wdata,
   output logic                          host_err,
   output logic                          bus_overrun,
   input  logic                          err_clr,
`ifdef SID_ARB_SHADOW_EN
   input  logic [ADDR_W-1:0]             shadow_raddr,
   output logic [7:0]                    shadow_rdata,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   ps_t               state_reg, state_next;
   src_t              src;
   logic [ADDR_W-1:0] haddr_reg;
   logic              host_xfer, addr_ok, host_err_set, overrun_set;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [ADDR_W+7:0] fifo_rdata;
   logic              pend_valid_reg;
   logic [ADDR_W-1:0] pend_addr_reg, sel_addr;
   logic [7:0]        pend_data_reg, sel_data;

   assign host_xfer    = host_valid && host_ready;
   assign addr_ok      = (host_data & (ADDR_MARK | RSV_MASK)) == ADDR_MARK;
   assign host_err_set = host_xfer && (state_reg == PS_ADDR) && !addr_ok;
   // Off-slot writes never coincide with a slot, so a valid pending entry is always lost here.
   assign overrun_set  = bus_we && !clk_en && pend_valid_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= PS_ADDR;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         PS_ADDR: if (host_xfer && addr_ok) state_next = PS_DATA;
         PS_DATA: if (host_xfer)            state_next = PS_ADDR;
         default: state_next = PS_ADDR;
      endcase
   end

   always_comb begin
      host_ready = (state_reg == PS_ADDR) || !fifo_full;
      fifo_push  = host_xfer && (state_reg == PS_DATA);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         haddr_reg <= '0;
      else if ((state_reg == PS_ADDR) && host_xfer && addr_ok)
         haddr_reg <= host_data[ADDR_W-1:0];
   end

   sid_arb_fifo #(
      .WIDTH (ADDR_W + 8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data ({haddr_reg, host_data}),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_comb begin
      src      = SRC_NONE;
      sel_addr = bus_addr;
      sel_data = bus_wdata;
      if (bus_we) begin
         src = SRC_BUS;
      end else if (pend_valid_reg) begin
         src      = SRC_PEND;
         sel_addr = pend_addr_reg;
         sel_data = pend_data_reg;
      end else if (!fifo_empty) begin
         src      = SRC_HOST;
         sel_addr = fifo_rdata[ADDR_W+7:8];
         sel_data = fifo_rdata[7:0];
      end
   end

   assign fifo_pop = clk_en && (src == SRC_HOST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid_reg <= 1'b0;
         pend_addr_reg  <= '0;
         pend_data_reg  <= '0;
      end else if (bus_we && !clk_en) begin
         pend_valid_reg <= 1'b1;
         pend_addr_reg  <= bus_addr;
         pend_data_reg  <= bus_wdata;
      end else if (clk_en && (src == SRC_PEND)) begin
         pend_valid_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sid_clk_en <= 1'b0;
         sid_we     <= 1'b0;
         sid_addr   <= '0;
         sid_wdata  <= '0;
      end else begin
         sid_clk_en <= clk_en;
         sid_we     <= clk_en && (src != SRC_NONE);
         if (clk_en && (src != SRC_NONE)) begin
            sid_addr  <= sel_addr;
            sid_wdata <= sel_data;
         end
      end
   end

   // A new error event outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host_err    <= 1'b0;
         bus_overrun <= 1'b0;
      end else begin
         if (host_err_set)  host_err <= 1'b1;
         else if (err_clr)  host_err <= 1'b0;
         if (overrun_set)   bus_overrun <= 1'b1;
         else if (err_clr)  bus_overrun <= 1'b0;
      end
   end

`ifdef SID_ARB_SHADOW_EN
   localparam int SH_N = 1 << ADDR_W;
   logic [7:0] shadow_mem [SH_N];

   genvar gi;
   generate
      for (gi = 0; gi < SH_N; gi++) begin : g_shadow
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               shadow_mem[gi] <= '0;
            else if (sid_we && (sid_addr == ADDR_W'(gi)))
               shadow_mem[gi] <= sid_wdata;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         shadow_rdata <= '0;
      else
         shadow_rdata <= shadow_mem[shadow_raddr];
   end
`endif

endmodule

// File: doc/sid_write_arbiter.md
Name: sid_write_arbiter

Overview:
- Shares the SID register write port between the physical C64 bus (output of sid_bus_if) and a host register-write byte stream from the USB ACM out channel.
- Parses host bytes into (addr, data) pairs and buffers them in a small FIFO.
- Issues at most one SID write per 1 MHz clk_en slot. The C64 bus always has priority.
- Sits between sid_bus_if / muacm and the sid core, and drives the SID's iWE, iAddr, iDataW and clkEn.

Parameters:
- FIFO_DEPTH, 8, host write FIFO entries; power of two, minimum 2.
- ADDR_W, 5, SID register address width.

Ports:
- clk  input  1  system clock (sys_clk domain).
- rst_n  input  1  asynchronous active-low reset.
- clk_en  input  1  1 MHz SID slot strobe, one clk wide.
- bus_we  input  1  C64 bus write strobe.
- bus_addr  input  ADDR_W  C64 write address.
- bus_wdata  input  8  C64 write data.
- host_data  input  8  host byte stream.
- host_valid  input  1  host byte valid.
- host_ready  output  1  arbiter accepts host byte.
- sid_clk_en  output  1  clk_en delayed 1 cycle, to sid clkEn.
- sid_we  output  1  SID write enable, only ever high with sid_clk_en.
- sid_addr  output  ADDR_W  SID write address.
- sid_wdata  output  8  SID write data.
- host_err  output  1  sticky: malformed host byte dropped.
- bus_overrun  output  1  sticky: pending bus write overwritten.
- err_clr  input  1  synchronous clear of both sticky flags.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  host FIFO occupancy.

Behaviour:
- Reset values: all outputs 0 except host_ready = 1. Parser state is ADDR, FIFO is empty, bus pending register is invalid.
- Host parser, byte transfer occurs on host_valid && host_ready:
  - ADDR state: a byte with bit7=1 and bits6:5=00 latches addr = byte[4:0] and moves to DATA.
  - ADDR state: any other byte is dropped, host_err is set, state stays ADDR.
  - DATA state: any byte pushes {addr, byte} into the FIFO and returns to ADDR.
- host_ready = 1 in ADDR. In DATA, host_ready = !fifo_full, so no byte is ever lost.
- Bus capture:
  - bus_we with clk_en is a slot write, served immediately.
  - bus_we without clk_en loads the pending register (addr, data, valid).
  - If pending is already valid and not consumed in that cycle, it is overwritten and bus_overrun is set.
- Slot arbitration, evaluated in the clk_en cycle, in strict priority order:
  1. Live bus write (bus_we && clk_en).
  2. Pending bus write. If a live bus write occurs in the same slot, the pending register is kept (not dropped) and serviced at the next slot.
  3. FIFO head; it is popped in that cycle.
  4. None: sid_we = 0.
- Output registers: sid_clk_en, sid_we, sid_addr and sid_wdata are registered. There is 1 cycle of latency from the clk_en cycle, identical for every source.
- sid_addr / sid_wdata hold their last values when sid_we = 0.
- Simultaneous FIFO push and pop in the same cycle is legal; the level is unchanged. A push when full cannot occur (prevented by host_ready).
- Pointers wrap modulo FIFO_DEPTH.
- err_clr in the same cycle as a new error event: the set wins.
- rst_n assertion mid-operation immediately clears the FIFO, pending register, parser state and outputs. A half-received host pair is discarded.

Optional Feature:
- Macro SID_ARB_SHADOW_EN.
- Defined:
  - Adds a 32x8 shadow register file, written on every issued sid_we with sid_addr/sid_wdata.
  - Adds ports shadow_raddr (input ADDR_W) and shadow_rdata (output 8), registered with 1-cycle read latency.
  - Reset clears all shadow entries to 0.
- Undefined: the ports are absent and no storage is inferred.

Decomposition:
- Package sid_arb_pkg contains:
  - ADDR_W default.
  - Address-marker constants: ADDR_MARK bit 7, reserved mask 8'h60.
  - Parser state encoding {PS_ADDR, PS_DATA}.
  - Source-select encoding {SRC_NONE, SRC_BUS, SRC_PEND, SRC_HOST}.
- Sub-module sid_arb_fifo: synchronous FIFO of width ADDR_W+8 and depth FIFO_DEPTH, with push/pop/full/empty/level and async active-low reset.

Test Plan:
- Host bytes 8'h98, 8'h0F, no bus activity -> at the first clk_en after the push, next cycle sid_we=1, sid_addr=5'h18, sid_wdata=8'h0F; fifo_level returns to 0.
- bus_we with clk_en (addr 5'h04, data 8'h41) while FIFO holds {5'h01, 8'h20} -> bus write is issued first; host write is issued at the following clk_en.
- bus_we off-slot (5'h05, 8'h09), then another off-slot (5'h06, 8'h11) before clk_en -> only (5'h06, 8'h11) is issued; bus_overrun=1; err_clr clears it.
- Host byte 8'hE1 in ADDR state -> byte is dropped, host_err=1, parser stays in ADDR; subsequent 8'h81, 8'hAA produces a write of 5'h01 = 8'hAA.
- Stream 9 pairs with FIFO_DEPTH=8 and no clk_en -> host_ready=0 in DATA after 8 entries; enabling clk_en drains the FIFO in order, one write per slot, with no loss.
- Assert rst_n low after an address byte, release, send 8'h55 -> byte is treated as malformed (host_err=1); no SID write occurs.
